// File: rtl/m_div_controller_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : m_div_controller_pkg
//  Description : Shared definitions for the RV32M divide issue/control stage:
//                FUNCT3 encodings, controller state encoding and XLEN-derived
//                constants.
//  Revision    : 1.0 - initial release
// ============================================================================
package m_div_controller_pkg;

   localparam int XLEN_DEF      = 32;
   localparam int TAG_WIDTH_DEF = 5;

   // FUNCT3 encodings of the divide/remainder group (bit 2 set for all four)
   localparam logic [2:0] F3_DIV  = 3'b100;
   localparam logic [2:0] F3_DIVU = 3'b101;
   localparam logic [2:0] F3_REM  = 3'b110;
   localparam logic [2:0] F3_REMU = 3'b111;

   localparam logic [XLEN_DEF-1:0] MIN_SIGNED = {1'b1, {(XLEN_DEF-1){1'b0}}};
   localparam logic [XLEN_DEF-1:0] ALL_ONES   = {XLEN_DEF{1'b1}};

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_LAUNCH = 2'd1,
      ST_WAIT   = 2'd2,
      ST_DONE   = 2'd3
   } state_t;

endpackage : m_div_controller_pkg
`default_nettype wire

// File: rtl/m_div_special.sv
`default_nettype none
// ============================================================================
//  Module      : m_div_special
//  Description : Combinational detector for the RISC-V divide special cases
//                (divide-by-zero, signed overflow) and the architecturally
//                defined result that replaces the core in those cases.
//  Ports       : i_is_signed  DIV/REM operation
//                i_is_rem     REM/REMU operation (result is the remainder)
//                i_rs1/i_rs2  dividend / divisor
//                o_bypass     a special case applies, core must not be used
//                o_result     bypass result (zero when o_bypass is low)
//  Revision    : 1.0 - initial release
// ============================================================================
module m_div_special
   import m_div_controller_pkg::*;
#(
   parameter int XLEN = XLEN_DEF
) (
   input  logic            i_is_signed,
   input  logic            i_is_rem,
   input  logic [XLEN-1:0] i_rs1,
   input  logic [XLEN-1:0] i_rs2,
   output logic            o_bypass,
   output logic [XLEN-1:0] o_result
);

   localparam logic [XLEN-1:0] c_all_ones   = {XLEN{1'b1}};
   localparam logic [XLEN-1:0] c_min_signed = {1'b1, {(XLEN-1){1'b0}}};

   logic w_div_zero;
   logic w_overflow;

   assign w_div_zero = (i_rs2 == '0);
   // Most-negative / -1 overflows in two's complement; only signed ops care
   assign w_overflow = i_is_signed & (i_rs1 == c_min_signed) & (i_rs2 == c_all_ones);
   assign o_bypass   = w_div_zero | w_overflow;

   always_comb begin
      o_result = '0;
      if (w_div_zero) begin
         o_result = i_is_rem ? i_rs1 : c_all_ones;
      end else if (w_overflow) begin
         o_result = i_is_rem ? '0 : c_min_signed;
      end
   end

endmodule : m_div_special
`default_nettype wire

// File: rtl/m_div_controller.sv
`default_nettype none
// ============================================================================
//  Module      : m_div_controller
//  Description : Issue/control stage in front of the iterative divider core.
//                Decodes DIV/DIVU/REM/REMU, resolves special cases locally,
//                otherwise launches the core with a one-cycle start, holds the
//                operands stable and returns a registered result plus tag.
//  Ports       : clk, rst_n            clock / async active-low reset
//                i_stall               pipeline stall, freezes block and core
//                i_valid, i_funct3     request and operation select
//                i_rs1, i_rs2, i_tag   dividend, divisor, destination tag
//                o_busy                not idle, requests ignored
//                o_result_valid        o_result / o_tag_out valid this cycle
//                o_div_*               core control and held operands
//                i_div_quotient/remainder/ready  core results and done flag
//  Revision    : 1.0 - initial release
// ============================================================================
module m_div_controller
   import m_div_controller_pkg::*;
#(
   parameter int XLEN      = XLEN_DEF,
   parameter int TAG_WIDTH = TAG_WIDTH_DEF
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 i_stall,
   input  logic                 i_valid,
   input  logic [2:0]           i_funct3,
   input  logic [XLEN-1:0]      i_rs1,
   input  logic [XLEN-1:0]      i_rs2,
   input  logic [TAG_WIDTH-1:0] i_tag,
   output logic                 o_busy,
   output logic                 o_result_valid,
   output logic [XLEN-1:0]      o_result,
   output logic [TAG_WIDTH-1:0] o_tag_out,
   output logic                 o_div_start,
   output logic                 o_div_stall,
   output logic                 o_div_sign,
   output logic [XLEN-1:0]      o_div_dividend,
   output logic [XLEN-1:0]      o_div_divider,
   input  logic [XLEN-1:0]      i_div_quotient,
   input  logic [XLEN-1:0]      i_div_remainder,
   input  logic                 i_div_ready
);

   state_t               r_state;
   state_t               w_state_nxt;
   logic                 r_sign;
   logic                 r_rem;
   logic [XLEN-1:0]      r_dividend;
   logic [XLEN-1:0]      r_divider;
   logic [XLEN-1:0]      r_result;
   logic [TAG_WIDTH-1:0] r_tag;

   logic                 w_is_div_op;
   logic                 w_is_signed;
   logic                 w_is_rem;
   logic                 w_accept;
   logic                 w_capture;
   logic                 w_sp_bypass;
   logic [XLEN-1:0]      w_sp_result;

   // ------------------------------------------------------------------------
   // Decode
   // ------------------------------------------------------------------------
   assign w_is_div_op = (i_funct3 == F3_DIV) | (i_funct3 == F3_DIVU) |
                        (i_funct3 == F3_REM) | (i_funct3 == F3_REMU);
   assign w_is_signed = (i_funct3 == F3_DIV) | (i_funct3 == F3_REM);
   assign w_is_rem    = (i_funct3 == F3_REM) | (i_funct3 == F3_REMU);

   assign w_accept  = (r_state == ST_IDLE) & i_valid & w_is_div_op & ~i_stall;
   assign w_capture = (r_state == ST_WAIT) & i_div_ready & ~i_stall;

   m_div_special #(
      .XLEN (XLEN)
   ) u_special (
      .i_is_signed (w_is_signed),
      .i_is_rem    (w_is_rem),
      .i_rs1       (i_rs1),
      .i_rs2       (i_rs2),
      .o_bypass    (w_sp_bypass),
      .o_result    (w_sp_result)
   );

   // ------------------------------------------------------------------------
   // State machine
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_state <= ST_IDLE;
      end else begin
         r_state <= w_state_nxt;
      end
   end

   always_comb begin
      w_state_nxt    = r_state;
      o_busy         = 1'b1;
      o_result_valid = 1'b0;
      o_div_start    = 1'b0;
      case (r_state)
         ST_IDLE: begin
            o_busy = 1'b0;
            if (w_accept) begin
               w_state_nxt = w_sp_bypass ? ST_DONE : ST_LAUNCH;
            end
         end
         ST_LAUNCH: begin
            // Start stays high through a stall; the core is frozen alongside
            o_div_start = 1'b1;
            if (!i_stall) begin
               w_state_nxt = ST_WAIT;
            end
         end
         ST_WAIT: begin
            if (w_capture) begin
               w_state_nxt = ST_DONE;
            end
         end
         ST_DONE: begin
            o_result_valid = 1'b1;
            if (!i_stall) begin
               w_state_nxt = ST_IDLE;
            end
         end
         default: begin
            w_state_nxt = ST_IDLE;
         end
      endcase
   end

   // ------------------------------------------------------------------------
   // Operand, tag and result registers. Operands change only on accept, so
   // they stay stable for the core (remainder sign fix-up reads them).
   // ------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         r_sign     <= 1'b0;
         r_rem      <= 1'b0;
         r_dividend <= '0;
         r_divider  <= '0;
         r_result   <= '0;
         r_tag      <= '0;
      end else if (w_accept) begin
         r_sign     <= w_is_signed;
         r_rem      <= w_is_rem;
         r_dividend <= i_rs1;
         r_divider  <= i_rs2;
         r_tag      <= i_tag;
         if (w_sp_bypass) begin
            r_result <= w_sp_result;
         end
      end else if (w_capture) begin
         r_result <= r_rem ? i_div_remainder : i_div_quotient;
      end
   end

   assign o_result       = r_result;
   assign o_tag_out      = r_tag;
   assign o_div_stall    = i_stall;
   assign o_div_sign     = r_sign;
   assign o_div_dividend = r_dividend;
   assign o_div_divider  = r_divider;

endmodule : m_div_controller
`default_nettype wire

// File: tb/tb_m_div_controller.sv
`default_nettype none
// ============================================================================
//  Module      : tb_m_div_controller
//  Description : Directed self-checking bench for m_div_controller with a
//                behavioural divider core model.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_m_div_controller;
   import m_div_controller_pkg::*;

   logic        clk      = 1'b0;
   logic        rst_n    = 1'b0;
   logic        i_stall  = 1'b0;
   logic        i_valid  = 1'b0;
   logic [2:0]  i_funct3 = 3'b000;
   logic [31:0] i_rs1    = '0;
   logic [31:0] i_rs2    = '0;
   logic [4:0]  i_tag    = '0;

   logic        o_busy, o_result_valid, o_div_start, o_div_stall, o_div_sign;
   logic [31:0] o_result, o_div_dividend, o_div_divider;
   logic [4:0]  o_tag_out;
   logic [31:0] w_quot, w_rem;
   logic        w_ready;

   int n_vec     = 0;
   int n_bad     = 0;
   int start_cnt = 0;
   int core_cnt  = 0;

   always #5 clk = ~clk;

   m_div_controller #(.XLEN(32), .TAG_WIDTH(5)) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .i_stall         (i_stall),
      .i_valid         (i_valid),
      .i_funct3        (i_funct3),
      .i_rs1           (i_rs1),
      .i_rs2           (i_rs2),
      .i_tag           (i_tag),
      .o_busy          (o_busy),
      .o_result_valid  (o_result_valid),
      .o_result        (o_result),
      .o_tag_out       (o_tag_out),
      .o_div_start     (o_div_start),
      .o_div_stall     (o_div_stall),
      .o_div_sign      (o_div_sign),
      .o_div_dividend  (o_div_dividend),
      .o_div_divider   (o_div_divider),
      .i_div_quotient  (w_quot),
      .i_div_remainder (w_rem),
      .i_div_ready     (w_ready)
   );

   // Core model: no reset, frozen by stall, START has priority. Ready rises
   // 31 edges after the edge that samples START, giving 34 edges from the
   // accepting edge (counted as edge 1) to RESULT_VALID.
   always @(posedge clk) begin
      if (!o_div_stall) begin
         if (o_div_start)        core_cnt <= 31;
         else if (core_cnt != 0) core_cnt <= core_cnt - 1;
      end
   end
   assign w_ready = (core_cnt == 0);

   always_comb begin
      logic signed [31:0] sd, sv;
      sd = $signed(o_div_dividend);
      sv = $signed(o_div_divider);
      w_quot = 32'hDEADBEEF;
      w_rem  = 32'hDEADBEEF;
      if (core_cnt == 0) begin
         if (o_div_divider == 0) begin
            w_quot = '1;
            w_rem  = o_div_dividend;
         end else if (o_div_sign) begin
            if (o_div_dividend == MIN_SIGNED && o_div_divider == ALL_ONES) begin
               w_quot = MIN_SIGNED;
               w_rem  = '0;
            end else begin
               w_quot = sd / sv;
               w_rem  = sd % sv;
            end
         end else begin
            w_quot = o_div_dividend / o_div_divider;
            w_rem  = o_div_dividend % o_div_divider;
         end
      end
   end

   // Count START cycles the (unstalled) core actually sees
   always @(negedge clk) begin
      if (o_div_start && !i_stall) start_cnt <= start_cnt + 1;
   end

   initial begin
      #300000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   // ------------------------------------------------------------------------
   task automatic issue(input logic [2:0] f3, input logic [31:0] a, b,
                        input logic [4:0] tag);
      @(negedge clk);
      i_valid = 1'b1; i_funct3 = f3; i_rs1 = a; i_rs2 = b; i_tag = tag;
      @(posedge clk); #1;
      // Scramble inputs so anything not latched on accept shows up
      i_valid = 1'b0; i_funct3 = 3'b000;
      i_rs1 = 32'h0BAD0BAD; i_rs2 = 32'h0F0F0F0F; i_tag = 5'h1F;
   endtask

   // Returns edge count (accepting edge = 1) at which RESULT_VALID is seen
   task automatic wait_valid(input logic [31:0] a, b, input logic s,
                             input int stall_at, stall_len,
                             output int n, output bit busy_ok, ops_ok, dstall_ok);
      n = 1; busy_ok = 1; ops_ok = 1; dstall_ok = 1;
      while (!o_result_valid && n < 100) begin
         if (n == stall_at) i_stall = 1'b1;
         if (n == stall_at + stall_len) i_stall = 1'b0;
         #0;
         if (!o_busy) busy_ok = 0;
         if (o_div_dividend !== a || o_div_divider !== b || o_div_sign !== s) ops_ok = 0;
         if (o_div_stall !== i_stall) dstall_ok = 0;
         @(posedge clk); #1;
         n++;
      end
   endtask

   task automatic run_op(input string name, input logic [2:0] f3,
                         input logic [31:0] a, b, input logic [4:0] tag,
                         input logic [31:0] exp_res, input int exp_lat);
      int n, s0, exp_starts;
      bit busy_ok, ops_ok, dstall_ok;
      logic exp_sign;
      exp_sign   = (f3 == F3_DIV) || (f3 == F3_REM);
      exp_starts = (exp_lat == 1) ? 0 : 1;
      s0 = start_cnt;
      issue(f3, a, b, tag);
      wait_valid(a, b, exp_sign, 0, 0, n, busy_ok, ops_ok, dstall_ok);
      n_vec++; if (n !== exp_lat) begin n_bad++;
         $display("FAIL %s latency: got %0d edges, expected %0d", name, n, exp_lat); end
      n_vec++; if (o_result !== exp_res) begin n_bad++;
         $display("FAIL %s result: got %h, expected %h", name, o_result, exp_res); end
      n_vec++; if (o_tag_out !== tag) begin n_bad++;
         $display("FAIL %s tag: got %h, expected %h", name, o_tag_out, tag); end
      n_vec++; if (!busy_ok || o_busy !== 1'b1) begin n_bad++;
         $display("FAIL %s busy: dropped while op in flight (done busy=%b), expected 1", name, o_busy); end
      n_vec++; if (!ops_ok) begin n_bad++;
         $display("FAIL %s operands: changed before result, expected %h/%h sign %b", name, a, b, exp_sign); end
      n_vec++; if (start_cnt - s0 !== exp_starts) begin n_bad++;
         $display("FAIL %s start pulses: got %0d, expected %0d", name, start_cnt - s0, exp_starts); end
      @(posedge clk); #1;
      n_vec++; if (o_result_valid !== 1'b0 || o_busy !== 1'b0) begin n_bad++;
         $display("FAIL %s after done: valid=%b busy=%b, expected 0 0", name, o_result_valid, o_busy); end
   endtask

   // ------------------------------------------------------------------------
   task automatic test_reset();
      #12;
      n_vec++; if ({o_busy, o_result_valid, o_div_start, o_div_sign} !== 4'b0000) begin n_bad++;
         $display("FAIL reset flags: busy/valid/start/sign=%b%b%b%b, expected 0000",
                  o_busy, o_result_valid, o_div_start, o_div_sign); end
      n_vec++; if (o_result !== '0 || o_tag_out !== '0) begin n_bad++;
         $display("FAIL reset result/tag: got %h/%h, expected 0/0", o_result, o_tag_out); end
      n_vec++; if (o_div_dividend !== '0 || o_div_divider !== '0) begin n_bad++;
         $display("FAIL reset operands: got %h/%h, expected 0/0", o_div_dividend, o_div_divider); end
      @(negedge clk); rst_n = 1'b1;
      @(posedge clk); #1;
      n_vec++; if (o_busy !== 1'b0) begin n_bad++;
         $display("FAIL reset idle busy: got %b, expected 0", o_busy); end
   endtask

   task automatic test_divu();
      run_op("divu_100_7", F3_DIVU, 32'd100, 32'd7, 5'd3, 32'h0000000E, 34);
   endtask

   task automatic test_signed();
      run_op("rem_m7_2", F3_REM, 32'hFFFFFFF9, 32'd2, 5'd10, 32'hFFFFFFFF, 34);
      run_op("div_m7_2", F3_DIV, 32'hFFFFFFF9, 32'd2, 5'd11, 32'hFFFFFFFD, 34);
   endtask

   task automatic test_div_zero();
      run_op("div_5_0",  F3_DIV,  32'd5, 32'd0, 5'd12, 32'hFFFFFFFF, 1);
      run_op("remu_5_0", F3_REMU, 32'd5, 32'd0, 5'd13, 32'h00000005, 1);
   endtask

   task automatic test_overflow();
      run_op("div_ovf", F3_DIV, 32'h80000000, 32'hFFFFFFFF, 5'd14, 32'h80000000, 1);
      run_op("rem_ovf", F3_REM, 32'h80000000, 32'hFFFFFFFF, 5'd15, 32'h00000000, 1);
   endtask

   task automatic test_stall();
      int n, s0, held;
      bit busy_ok, ops_ok, dstall_ok;
      s0 = start_cnt;
      issue(F3_DIVU, 32'd1000, 32'd10, 5'd7);
      // Stall during WAIT across edges 11..13
      wait_valid(32'd1000, 32'd10, 1'b0, 10, 3, n, busy_ok, ops_ok, dstall_ok);
      n_vec++; if (n !== 37) begin n_bad++;
         $display("FAIL stall latency: got %0d edges, expected 37", n); end
      n_vec++; if (o_result !== 32'd100) begin n_bad++;
         $display("FAIL stall result: got %h, expected %h", o_result, 32'd100); end
      n_vec++; if (!ops_ok || !busy_ok || !dstall_ok) begin n_bad++;
         $display("FAIL stall hold: ops_ok=%b busy_ok=%b div_stall_ok=%b, expected 1 1 1",
                  ops_ok, busy_ok, dstall_ok); end
      n_vec++; if (start_cnt - s0 !== 1) begin n_bad++;
         $display("FAIL stall start pulses: got %0d, expected 1", start_cnt - s0); end
      // Two stalled cycles in DONE: valid held for three cycles in total
      held = 1;
      i_stall = 1'b1;
      repeat (2) begin
         @(posedge clk); #1;
         if (o_result_valid && o_result === 32'd100 && o_tag_out === 5'd7) held++;
      end
      i_stall = 1'b0;
      @(posedge clk); #1;
      n_vec++; if (held !== 3 || o_result_valid !== 1'b0) begin n_bad++;
         $display("FAIL stall done hold: held %0d cycles then valid=%b, expected 3 then 0",
                  held, o_result_valid); end
   endtask

   task automatic test_ignored();
      int n, s0;
      bit ops_ok;
      s0 = start_cnt;
      // FUNCT3 000 is not a request, even with a divide-by-zero divisor
      @(negedge clk);
      i_valid = 1'b1; i_funct3 = 3'b000; i_rs1 = 32'd123; i_rs2 = 32'd0; i_tag = 5'd21;
      @(posedge clk); #1;
      @(posedge clk); #1;
      i_valid = 1'b0;
      n_vec++; if (o_busy !== 1'b0 || o_result_valid !== 1'b0 || o_div_dividend !== 32'd1000) begin n_bad++;
         $display("FAIL funct3_000: busy=%b valid=%b dividend=%h, expected 0 0 %h",
                  o_busy, o_result_valid, o_div_dividend, 32'd1000); end
      // A request while busy must not disturb the op in flight
      issue(F3_DIVU, 32'd50, 32'd5, 5'd2);
      n = 1; ops_ok = 1;
      while (!o_result_valid && n < 100) begin
         if (n == 5) begin
            i_valid = 1'b1; i_funct3 = F3_DIV; i_rs1 = 32'd77; i_rs2 = 32'd0; i_tag = 5'd9;
         end
         if (n == 6) i_valid = 1'b0;
         if (o_div_dividend !== 32'd50 || o_div_divider !== 32'd5 || o_div_sign !== 1'b0) ops_ok = 0;
         @(posedge clk); #1;
         n++;
      end
      i_valid = 1'b0;
      n_vec++; if (n !== 34 || o_result !== 32'd10 || o_tag_out !== 5'd2) begin n_bad++;
         $display("FAIL busy_ignore result: lat %0d res %h tag %h, expected 34 %h 02",
                  n, o_result, o_tag_out, 32'd10); end
      n_vec++; if (!ops_ok || start_cnt - s0 !== 1) begin n_bad++;
         $display("FAIL busy_ignore ops: ops_ok=%b starts=%0d, expected 1 1", ops_ok, start_cnt - s0); end
      @(posedge clk); #1;
      repeat (3) begin @(posedge clk); #1; end
      n_vec++; if (o_result_valid !== 1'b0 || o_busy !== 1'b0) begin n_bad++;
         $display("FAIL busy_ignore after: valid=%b busy=%b, expected 0 0", o_result_valid, o_busy); end
   endtask

   task automatic test_reset_mid();
      issue(F3_DIVU, 32'h12345678, 32'd3, 5'd4);
      repeat (14) begin @(posedge clk); #1; end
      #2 rst_n = 1'b0;
      #1;
      n_vec++; if ({o_busy, o_result_valid, o_div_start, o_div_sign} !== 4'b0000) begin n_bad++;
         $display("FAIL midreset flags: busy/valid/start/sign=%b%b%b%b, expected 0000",
                  o_busy, o_result_valid, o_div_start, o_div_sign); end
      n_vec++; if (o_result !== '0 || o_tag_out !== '0 || o_div_dividend !== '0 || o_div_divider !== '0) begin n_bad++;
         $display("FAIL midreset data: res %h tag %h dvd %h dvs %h, expected all 0",
                  o_result, o_tag_out, o_div_dividend, o_div_divider); end
      @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      run_op("divu_9_3", F3_DIVU, 32'd9, 32'd3, 5'd6, 32'd3, 34);
   endtask

   initial begin
      test_reset();
      test_divu();
      test_signed();
      test_div_zero();
      test_overflow();
      test_stall();
      test_ignored();
      test_reset_mid();
      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule : tb_m_div_controller
`default_nettype wire
